ssram_arbiter: RTL and testbench
================================

Name: ssram_arbiter

Overview:
- Two-port arbiter and sequencer for the ssram_256 register bank.
- Port A serves the MCU parallel bus; port B serves the internal core (HWAG).
- Serialises accesses and decodes an 8-bit address into one-hot row/column enables.
- Drives the write strobe, read strobe and data direction for the shared bank data bus, and returns read data with a single-cycle ack.

Parameters:
- WIDTH, 16, data width of the bank and both requester ports.
- DEPTH, 256, number of implemented registers (1..256); addresses >= DEPTH are out of range.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- a_req  input  1  port A request, held until a_ack
- a_we  input  1  port A: 1 = write, 0 = read
- a_addr  input  8  port A register address
- a_wdata  input  WIDTH  port A write data
- a_rdata  output  WIDTH  port A read data, valid while a_ack=1
- a_ack  output  1  port A completion pulse
- a_err  output  1  port A out-of-range flag, valid while a_ack=1
- b_req, b_we, b_addr, b_wdata, b_rdata, b_ack, b_err: same as port A, for port B
- ram_row  output  16  one-hot row enable = addr[7:4]
- ram_column  output  16  one-hot column enable = addr[3:0]
- ram_we  output  1  bank write strobe
- ram_re  output  1  bank read strobe (enables the bank tri-state buffers)
- ram_wdata  output  WIDTH  write data toward the bank bus
- ram_drive  output  1  1 = top-level buffer_z drives ram_wdata onto the bank bus
- ram_rdata  input  WIDTH  bank bus value (combinational read data)

Behaviour:
- Reset (rst=0, async):
  - State = IDLE.
  - All outputs 0.
  - Latched address, data and we registers = 0.
  - last_grant = B, so A wins the first tie.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No req: stay.
  - Exactly one req: grant that port.
  - Both req: grant the port != last_grant.
  - On grant: latch addr/we/wdata and the grant id, update last_grant, go to ACCESS.
- ACCESS (exactly 1 cycle):
  - ram_row/ram_column are one-hot from the latched address, provided address < DEPTH; otherwise both are 0.
  - Write: ram_we=1, ram_drive=1, ram_wdata = latched wdata; the bank captures on the closing edge.
  - Read: ram_re=1, ram_drive=0; ram_rdata is registered into the granted port's rdata on the closing edge.
  - Next state: ACK.
- ACK (1 cycle):
  - The granted port's ack=1; err=1 if its address >= DEPTH.
  - rdata holds its value; it is 0 for writes and for out-of-range reads.
  - The other port's ack/err = 0.
  - Next state: IDLE.
- Latency:
  - Request sampled in IDLE at edge N; ack is high during cycle N+2 (3-cycle transaction).
  - Back-to-back transactions on alternating ports: one every 3 cycles.
- Requester rules:
  - req must stay high until ack.
  - req still high in the cycle after ack starts a new transaction.
  - req dropped before grant: the request is withdrawn, no ack.
  - addr/we/wdata need only be stable on the grant edge.
- ram_we, ram_re and ram_drive are never 1 outside ACCESS and never simultaneously 1 with each other (except ram_drive together with ram_we).
- Out-of-range addresses:
  - No row/column enable is asserted, so a write is dropped.
  - A read returns 0.
  - The FSM still completes with ack and err=1.
- rdata of the non-granted port keeps its previous value.
- Reset asserted mid-transaction: immediate abort to IDLE, all strobes low, no ack issued, partial write not guaranteed.
- ram_rdata is sampled only in ACCESS of a read; any X or Z elsewhere is ignored.

Decomposition:
- Package ssram_arbiter_pkg holds:
  - the state enum (IDLE/ACCESS/ACK)
  - ADDR_W=8, ROW_W=16, COL_W=16
  - the port-id enum (PORT_A, PORT_B)
- Sub-module onehot16_decode:
  - 4-bit index plus enable in, 16-bit one-hot out.
  - Instantiated twice, once for the row and once for the column.
  - Enable = ACCESS & (addr < DEPTH).

Test Plan:
- Reset then a single A write: a_addr=0x23, a_wdata=0xBEEF.
  - In ACCESS: ram_row=0x0004, ram_column=0x0008, ram_we=1, ram_drive=1, ram_wdata=0xBEEF.
  - a_ack is high 2 cycles after the grant edge, a_err=0.
- A read of 0x23 with the bank model returning 0xBEEF: in ACCESS ram_re=1, ram_drive=0; a_rdata=0xBEEF during a_ack.
- a_req and b_req rise in the same cycle, both held:
  - Grant order A, B, A, B.
  - Acks 3 cycles apart.
  - Each rdata is returned only to its own port.
- DEPTH=200, B write to 0xC8:
  - ram_row/column=0, ram_we=1.
  - b_ack with b_err=1, bank content unchanged.
  - A read of 0xC8 returns 0 with err=1.
- rst pulled low during ACCESS of an A write: all ram_* outputs 0 immediately, no a_ack; after release, A (still requesting) is re-granted and completes.
- a_req pulsed for 1 cycle while B is in ACCESS: no A grant, no a_ack, FSM returns to IDLE after b_ack.

Source files
------------

// File: rtl/ssram_arbiter_pkg.sv
// ssram_arbiter_pkg: shared types and widths for the ssram_256 arbiter
package ssram_arbiter_pkg;
    localparam int ADDR_W = 8;
    localparam int ROW_W  = 16;
    localparam int COL_W  = 16;
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    typedef enum logic {PORT_A, PORT_B} port_t;
endpackage

// File: rtl/ssram_arbiter_if.sv
// ssram_arbiter_if: requester ports and bank bus of the ssram_256 arbiter
interface ssram_arbiter_if #(parameter int WIDTH = 16);
    import ssram_arbiter_pkg::*;
    logic              a_req, a_we, a_ack, a_err;
    logic [ADDR_W-1:0] a_addr;
    logic [WIDTH-1:0]  a_wdata, a_rdata;
    logic              b_req, b_we, b_ack, b_err;
    logic [ADDR_W-1:0] b_addr;
    logic [WIDTH-1:0]  b_wdata, b_rdata;
    logic [ROW_W-1:0]  ram_row;
    logic [COL_W-1:0]  ram_column;
    logic              ram_we, ram_re, ram_drive;
    logic [WIDTH-1:0]  ram_wdata, ram_rdata;
    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_rdata,
        input  a_rdata, a_ack, a_err, b_rdata, b_ack, b_err,
        input  ram_row, ram_column, ram_we, ram_re, ram_drive, ram_wdata
    );
    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_rdata,
        output a_rdata, a_ack, a_err, b_rdata, b_ack, b_err,
        output ram_row, ram_column, ram_we, ram_re, ram_drive, ram_wdata
    );
endinterface

// File: rtl/onehot16_decode.sv
// onehot16_decode: 4-bit index to 16-bit one-hot, all zero when disabled
module onehot16_decode (
    input  logic [3:0]  idx_i,
    input  logic        en_i,
    output logic [15:0] onehot_o
);
    assign onehot_o = en_i ? 16'(1) << idx_i : '0;
endmodule

// File: rtl/ssram_arbiter.sv
// ssram_arbiter: round-robin two-port sequencer for the ssram_256 bank,
// one IDLE/ACCESS/ACK pass per access with one-hot row/column decode.
module ssram_arbiter
    import ssram_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
) (
    input logic           clk,
    input logic           rst,
    ssram_arbiter_if.slave bus
);
    state_t            state_q;
    port_t             gnt_q, last_q, gnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q, we_d;
    logic [WIDTH-1:0]  wdata_q, a_rdata_q, b_rdata_q, rdata_d;
    logic              a_ack_q, b_ack_q, a_err_q, b_err_q, ram_we_q, ram_re_q;
    logic              grant_a, grant_b, in_range, dec_en;
    // A wins unless B also asks and A was served last
    assign grant_a  = bus.a_req & (~bus.b_req | last_q == PORT_B);
    assign grant_b  = bus.b_req & ~grant_a;
    assign gnt_d    = grant_a ? PORT_A : PORT_B;
    assign we_d     = grant_a ? bus.a_we : bus.b_we;
    assign in_range = int'(addr_q) < DEPTH;
    assign dec_en   = state_q == ACCESS && in_range;
    assign rdata_d  = (we_q | ~in_range) ? '0 : bus.ram_rdata;
    onehot16_decode u_row (.idx_i(addr_q[7:4]), .en_i(dec_en), .onehot_o(bus.ram_row));
    onehot16_decode u_col (.idx_i(addr_q[3:0]), .en_i(dec_en), .onehot_o(bus.ram_column));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_q     <= PORT_A;
            last_q    <= PORT_B;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
            ram_we_q  <= 1'b0;
            ram_re_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (grant_a | grant_b) begin
                    gnt_q    <= gnt_d;
                    last_q   <= gnt_d;
                    addr_q   <= grant_a ? bus.a_addr : bus.b_addr;
                    wdata_q  <= grant_a ? bus.a_wdata : bus.b_wdata;
                    we_q     <= we_d;
                    ram_we_q <= we_d;
                    ram_re_q <= ~we_d;
                    state_q  <= ACCESS;
                end
                ACCESS: begin
                    ram_we_q  <= 1'b0;
                    ram_re_q  <= 1'b0;
                    a_rdata_q <= gnt_q == PORT_A ? rdata_d : a_rdata_q;
                    b_rdata_q <= gnt_q == PORT_B ? rdata_d : b_rdata_q;
                    a_ack_q   <= gnt_q == PORT_A;
                    b_ack_q   <= gnt_q == PORT_B;
                    a_err_q   <= gnt_q == PORT_A && !in_range;
                    b_err_q   <= gnt_q == PORT_B && !in_range;
                    state_q   <= ACK;
                end
                default: begin
                    a_ack_q <= 1'b0;
                    b_ack_q <= 1'b0;
                    a_err_q <= 1'b0;
                    b_err_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.a_ack     = a_ack_q;
    assign bus.b_ack     = b_ack_q;
    assign bus.a_err     = a_err_q;
    assign bus.b_err     = b_err_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_re    = ram_re_q;
    assign bus.ram_drive = ram_we_q;
    assign bus.ram_wdata = wdata_q;
endmodule

// File: tb/tb_ssram_arbiter.sv
// tb_ssram_arbiter: bank model plus scoreboard of expected acks for ssram_arbiter
module tb_ssram_arbiter;
    typedef struct packed {logic [15:0] rdata; logic err;} exp_t;
    typedef struct {bit pb; bit we; logic [7:0] addr; logic [15:0] wdata; logic [15:0] rd; bit err;} vec_t;
    logic clk = 0, rst = 0;
    int n_cmp = 0, n_bad = 0;
    exp_t qa[$], qb[$];
    logic [15:0] hold_a = 0, hold_b = 0;
    bit got_a, got_b;
    logic [15:0] mem [256] = '{default: 16'h0};
    int ri, ci;
    vec_t tbl [10];
    ssram_arbiter_if #(.WIDTH(16)) bus ();
    ssram_arbiter #(.WIDTH(16), .DEPTH(200)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic int oh_idx(logic [15:0] v);
        int r = -1;
        for (int i = 0; i < 16; i++) if (v[i]) r = (r == -1) ? i : -2;
        return r;
    endfunction
    always_comb begin
        ri = oh_idx(bus.ram_row);
        ci = oh_idx(bus.ram_column);
    end
    assign bus.ram_rdata = (bus.ram_re && ri >= 0 && ci >= 0) ? mem[ri*16+ci] : 16'hzzzz;
    always @(posedge clk) if (bus.ram_we && ri >= 0 && ci >= 0) mem[ri*16+ci] <= bus.ram_wdata;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
        end
    endtask
    task automatic mon();
        exp_t e;
        got_a = bus.a_ack;
        got_b = bus.b_ack;
        if (bus.a_ack) begin
            if (qa.size() == 0) chk("a_unexpected_ack", bus.a_ack, 0);
            else begin
                e = qa.pop_front();
                chk("a_rdata", bus.a_rdata, e.rdata);
                chk("a_err", bus.a_err, e.err);
            end
            chk("b_rdata_hold", bus.b_rdata, hold_b);
            hold_a = bus.a_rdata;
        end
        if (bus.b_ack) begin
            if (qb.size() == 0) chk("b_unexpected_ack", bus.b_ack, 0);
            else begin
                e = qb.pop_front();
                chk("b_rdata", bus.b_rdata, e.rdata);
                chk("b_err", bus.b_err, e.err);
            end
            chk("a_rdata_hold", bus.a_rdata, hold_a);
            hold_b = bus.b_rdata;
        end
        chk("strobe_excl", bus.ram_re & (bus.ram_we | bus.ram_drive), 0);
    endtask
    task automatic tick();
        @(posedge clk);
        #1 mon();
    endtask
    task automatic wait_ack(input bit pb);
        int n = 0;
        do begin tick(); n++; end while (!(pb ? got_b : got_a) && n < 8);
        chk(pb ? "b_ack_timeout" : "a_ack_timeout", pb ? got_b : got_a, 1);
    endtask
    task automatic run_txn(input vec_t v);
        if (v.pb) begin
            bus.b_we = v.we; bus.b_addr = v.addr; bus.b_wdata = v.wdata; bus.b_req = 1;
            qb.push_back('{v.rd, v.err});
        end else begin
            bus.a_we = v.we; bus.a_addr = v.addr; bus.a_wdata = v.wdata; bus.a_req = 1;
            qa.push_back('{v.rd, v.err});
        end
        wait_ack(v.pb);
        bus.a_req = 0;
        bus.b_req = 0;
    endtask
    task automatic do_reset();
        rst = 0;
        bus.a_req = 0; bus.b_req = 0;
        qa.delete(); qb.delete();
        hold_a = 0; hold_b = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1;
        tick();
    endtask
    initial begin
        #200000 $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
        tbl[0] = '{1, 1, 8'h10, 16'h1234, 16'h0000, 0};
        tbl[1] = '{0, 1, 8'h45, 16'hA5A5, 16'h0000, 0};
        tbl[2] = '{1, 0, 8'h45, 16'h0000, 16'hA5A5, 0};
        tbl[3] = '{0, 0, 8'h10, 16'h0000, 16'h1234, 0};
        tbl[4] = '{0, 1, 8'hC7, 16'h7777, 16'h0000, 0};
        tbl[5] = '{1, 0, 8'hC7, 16'h0000, 16'h7777, 0};
        tbl[6] = '{0, 0, 8'hC8, 16'h0000, 16'h0000, 1};
        tbl[7] = '{0, 1, 8'hFF, 16'h5555, 16'h0000, 1};
        tbl[8] = '{1, 0, 8'h23, 16'h0000, 16'hBEEF, 0};
        tbl[9] = '{1, 0, 8'hFF, 16'h0000, 16'h0000, 1};
        // reset state
        tick();
        chk("rst_a_ack", bus.a_ack, 0); chk("rst_b_ack", bus.b_ack, 0);
        chk("rst_a_err", bus.a_err, 0); chk("rst_b_err", bus.b_err, 0);
        chk("rst_a_rdata", bus.a_rdata, 0); chk("rst_b_rdata", bus.b_rdata, 0);
        chk("rst_row", bus.ram_row, 0); chk("rst_col", bus.ram_column, 0);
        chk("rst_we", bus.ram_we, 0); chk("rst_re", bus.ram_re, 0);
        chk("rst_drive", bus.ram_drive, 0); chk("rst_wdata", bus.ram_wdata, 0);
        #2 rst = 1;
        tick();
        // single A write with latency check
        bus.a_we = 1; bus.a_addr = 8'h23; bus.a_wdata = 16'hBEEF; bus.a_req = 1;
        qa.push_back('{16'h0, 1'b0});
        tick();
        chk("w_row", bus.ram_row, 16'h0004); chk("w_col", bus.ram_column, 16'h0008);
        chk("w_we", bus.ram_we, 1); chk("w_drive", bus.ram_drive, 1);
        chk("w_re", bus.ram_re, 0); chk("w_wdata", bus.ram_wdata, 16'hBEEF);
        chk("w_early_ack", bus.a_ack, 0);
        tick();
        chk("w_ack_latency", got_a, 1);
        bus.a_req = 0;
        tick();
        // A read back
        bus.a_we = 0; bus.a_req = 1;
        qa.push_back('{16'hBEEF, 1'b0});
        tick();
        chk("r_re", bus.ram_re, 1); chk("r_drive", bus.ram_drive, 0); chk("r_we", bus.ram_we, 0);
        chk("r_row", bus.ram_row, 16'h0004); chk("r_col", bus.ram_column, 16'h0008);
        tick();
        chk("r_ack_latency", got_a, 1);
        bus.a_req = 0;
        tick();
        // out-of-range B write is dropped
        bus.b_we = 1; bus.b_addr = 8'hC8; bus.b_wdata = 16'hDEAD; bus.b_req = 1;
        qb.push_back('{16'h0, 1'b1});
        tick();
        chk("oor_row", bus.ram_row, 0); chk("oor_col", bus.ram_column, 0); chk("oor_we", bus.ram_we, 1);
        tick();
        chk("oor_ack", got_b, 1);
        bus.b_req = 0;
        tick();
        chk("oor_bank_c8", mem[200], 0);
        // table-driven transactions
        for (int i = 0; i < 10; i++) run_txn(tbl[i]);
        tick();
        // simultaneous requests held: A, B, A, B every 3 cycles
        do_reset();
        bus.a_we = 0; bus.a_addr = 8'h10; bus.b_we = 0; bus.b_addr = 8'h45;
        repeat (2) begin qa.push_back('{16'h1234, 1'b0}); qb.push_back('{16'hA5A5, 1'b0}); end
        bus.a_req = 1; bus.b_req = 1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            chk("tie_ack_order", {got_b, got_a}, (t == 2 || t == 8) ? 2'b01 : (t == 5 || t == 11) ? 2'b10 : 2'b00);
            if (t == 11) begin bus.a_req = 0; bus.b_req = 0; end
        end
        chk("tie_queue_a_empty", qa.size(), 0);
        chk("tie_queue_b_empty", qb.size(), 0);
        // reset during ACCESS of an A write
        bus.a_we = 1; bus.a_addr = 8'h30; bus.a_wdata = 16'h1111; bus.a_req = 1;
        tick();
        #2 rst = 0;
        #1;
        chk("abort_we", bus.ram_we, 0); chk("abort_re", bus.ram_re, 0); chk("abort_drive", bus.ram_drive, 0);
        chk("abort_row", bus.ram_row, 0); chk("abort_col", bus.ram_column, 0); chk("abort_ack", bus.a_ack, 0);
        hold_a = 0; hold_b = 0;
        tick(); tick();
        #2 rst = 1;
        qa.push_back('{16'h0, 1'b0});
        wait_ack(0);
        bus.a_req = 0;
        tick();
        run_txn('{0, 0, 8'h30, 16'h0, 16'h1111, 0});
        tick();
        // one-cycle A pulse while B is in ACCESS is ignored
        bus.b_we = 0; bus.b_addr = 8'h45; bus.b_req = 1;
        qb.push_back('{16'hA5A5, 1'b0});
        tick();
        bus.a_we = 0; bus.a_addr = 8'h10; bus.a_req = 1;
        tick();
        chk("pulse_b_ack", got_b, 1);
        bus.a_req = 0; bus.b_req = 0;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("pulse_no_grant", bus.ram_re | bus.ram_we | bus.a_ack, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
